// File: rtl/fnd_scan_controller.sv
// Four-digit seven-segment scan controller: binary capture, double-dabble BCD
// conversion and time-multiplexed active-low font output with leading-zero blanking.
module fnd_scan_controller #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 4_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_blank_en,
    output logic [1:0]  o_digit,
    output logic [7:0]  o_font,
    output logic        o_busy
);

    localparam int unsigned DIV    = CLK_HZ / SCAN_HZ;
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned VAL_W  = 14;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned ITER_W = 4;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [VAL_W-1:0]  VAL_MAX  = VAL_W'(9999);
    localparam logic [ITER_W-1:0] N_ITER   = ITER_W'(VAL_W);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q;
    logic [1:0]          digit_q;
    logic                tick;
    logic [VAL_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    work_q, work_d;
    logic [BCD_W-1:0]    disp_q, disp_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                busy_q, busy_d;
    logic [BCD_W-1:0]    dab;
    logic [3:0]          nib;
    logic                blank;

    // Scan divider and digit index run free of the conversion FSM
    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_q   <= '0;
            digit_q <= '0;
        end else if (tick) begin
            div_q   <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            div_q   <= div_q + DIV_W'(1);
        end
    end

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        dab = work_q;
        for (int i = 0; i < 4; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                dab[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            disp_q  <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            disp_q  <= disp_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        disp_d  = disp_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (i_load) begin
                    bin_d   = (i_value > VAL_MAX) ? VAL_MAX : i_value;
                    work_d  = '0;
                    iter_d  = N_ITER;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                work_d = {dab[BCD_W-2:0], bin_q[VAL_W-1]};
                bin_d  = {bin_q[VAL_W-2:0], 1'b0};
                iter_d = iter_q - ITER_W'(1);
                if (iter_q == ITER_W'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                disp_d  = work_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Font lookup; a position blanks when it and every higher digit are zero
    always_comb begin
        nib   = disp_q[3:0];
        blank = 1'b0;
        case (digit_q)
            2'd0: begin
                nib   = disp_q[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = disp_q[7:4];
                blank = (disp_q[15:4] == 12'd0);
            end
            2'd2: begin
                nib   = disp_q[11:8];
                blank = (disp_q[15:8] == 8'd0);
            end
            default: begin
                nib   = disp_q[15:12];
                blank = (disp_q[15:12] == 4'd0);
            end
        endcase
        o_font = 8'hFF;
        if (!(i_blank_en && blank)) begin
            case (nib)
                4'd0:    o_font = 8'hC0;
                4'd1:    o_font = 8'hF9;
                4'd2:    o_font = 8'hA4;
                4'd3:    o_font = 8'hB0;
                4'd4:    o_font = 8'h99;
                4'd5:    o_font = 8'h92;
                4'd6:    o_font = 8'h82;
                4'd7:    o_font = 8'hF8;
                4'd8:    o_font = 8'h80;
                4'd9:    o_font = 8'h90;
                default: o_font = 8'hFF;
            endcase
        end
    end

    assign o_digit = digit_q;
    assign o_busy  = busy_q;

endmodule
